// File: rtl/load_store_unit.sv
// Data-memory initiator: one load/store at a time, sub-word stores done as read-modify-write.
// Optional feature: define MISALIGN_TRAP_EN to reject misaligned H/HU/W requests.
module load_store_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic             req_we_i,
  input  logic [2:0]       req_funct3_i,
  input  logic [WIDTH-1:0] req_addr_i,
  input  logic [WIDTH-1:0] req_wdata_i,
  output logic             rsp_valid_o,
  output logic [WIDTH-1:0] rsp_rdata_o,
  output logic             rsp_err_o,
  output logic [WIDTH-1:0] mem_a_o,
  output logic             mem_we_o,
  output logic [WIDTH-1:0] mem_wd_o,
  input  logic [WIDTH-1:0] mem_rd_i
);

  typedef enum logic [1:0] {IDLE, ACCESS, MERGE_WR, RESP} state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  state_e           state_q, state_d;
  logic             we_q;
  logic [2:0]       funct3_q;
  logic [WIDTH-1:0] addr_q, wdata_q;
  logic             err_q;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic [WIDTH-1:0] mem_wd_q, mem_wd_d;

  logic             req_fire;
  logic             req_illegal;
  logic             sub_word_store;
  logic [WIDTH-1:0] load_fmt;
  logic [WIDTH-1:0] merge_word;

  assign req_fire       = req_valid_i && (state_q == IDLE);
  assign sub_word_store = we_q && !err_q && (funct3_q != F3_W);

  always_comb begin
    req_illegal = 1'b0;
    unique case (req_funct3_i)
      F3_B, F3_H, F3_W: req_illegal = 1'b0;
      F3_BU, F3_HU:     req_illegal = req_we_i;
      default:          req_illegal = 1'b1;
    endcase
`ifdef MISALIGN_TRAP_EN
    if ((req_funct3_i[1:0] == 2'b01) && req_addr_i[0])
      req_illegal = 1'b1;
    if ((req_funct3_i == F3_W) && (req_addr_i[1:0] != 2'b00))
      req_illegal = 1'b1;
`endif
  end

  always_comb begin
    load_fmt = '0;
    unique case (funct3_q)
      F3_B:    load_fmt = {{24{mem_rd_i[7]}}, mem_rd_i[7:0]};
      F3_H:    load_fmt = {{16{mem_rd_i[15]}}, mem_rd_i[15:0]};
      F3_W:    load_fmt = mem_rd_i;
      F3_BU:   load_fmt = {24'h0, mem_rd_i[7:0]};
      F3_HU:   load_fmt = {16'h0, mem_rd_i[15:0]};
      default: load_fmt = '0;
    endcase
  end

  assign merge_word = (funct3_q == F3_B) ? {mem_rd_i[31:8], wdata_q[7:0]}
                                         : {mem_rd_i[31:16], wdata_q[15:0]};

  // NOTE: every register, including the request latches, is cleared by the async reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      // NOTE: non-blocking so all registers update from the same pre-edge values.
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      we_q     <= 1'b0;
      funct3_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      mem_wd_q <= '0;
    end else begin
      if (req_fire) begin
        we_q     <= req_we_i;
        funct3_q <= req_funct3_i;
        addr_q   <= req_addr_i;
        wdata_q  <= req_wdata_i;
        err_q    <= req_illegal;
      end
      rdata_q  <= rdata_d;
      mem_wd_q <= mem_wd_d;
    end
  end

  // Rejected requests still spend one cycle in ACCESS (memory untouched) so every
  // single-access response arrives with the same latency.
  always_comb begin
    // NOTE: defaults first so no path through the case leaves a signal unassigned (no latch).
    rdata_d  = rdata_q;
    mem_wd_d = mem_wd_q;
    if (req_fire && req_we_i && !req_illegal && (req_funct3_i == F3_W))
      mem_wd_d = req_wdata_i;
    if (state_q == ACCESS) begin
      rdata_d = (we_q || err_q) ? '0 : load_fmt;
      if (sub_word_store)
        mem_wd_d = merge_word;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (req_valid_i) state_d = ACCESS;
      ACCESS:   state_d = sub_word_store ? MERGE_WR : RESP;
      MERGE_WR: state_d = RESP;
      RESP:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready_o = (state_q == IDLE);
    rsp_valid_o = (state_q == RESP);
    rsp_err_o   = (state_q == RESP) && err_q;
    rsp_rdata_o = rdata_q;
    mem_a_o     = addr_q;
    mem_wd_o    = mem_wd_q;
    mem_we_o    = (state_q == MERGE_WR) ||
                  ((state_q == ACCESS) && we_q && !err_q && (funct3_q == F3_W));
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit with a byte-array memory model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] mem_a;
  logic        mem_we;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] mem [0:255];

  always #5 clk = ~clk;

  load_store_unit #(.WIDTH(32)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_we_i    (req_we),
    .req_funct3_i(req_funct3),
    .req_addr_i  (req_addr),
    .req_wdata_i (req_wdata),
    .rsp_valid_o (rsp_valid),
    .rsp_rdata_o (rsp_rdata),
    .rsp_err_o   (rsp_err),
    .mem_a_o     (mem_a),
    .mem_we_o    (mem_we),
    .mem_wd_o    (mem_wd),
    .mem_rd_i    (mem_rd)
  );

  // Memory window covers 0x10000..0x100FF via the low address byte.
  assign mem_rd = {mem[mem_a[7:0] + 8'd3], mem[mem_a[7:0] + 8'd2],
                   mem[mem_a[7:0] + 8'd1], mem[mem_a[7:0]]};

  always @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++)
        mem[mem_a[7:0] + 8'(i)] <= mem_wd[8*i +: 8];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issue one request, track MEM_WE per cycle after accept and the response cycle.
  task automatic run(input string tag, input logic we, input logic [2:0] f3,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [31:0] exp_rdata, input logic exp_err,
                     input int exp_lat, input logic [7:0] exp_we_mask);
    int          lat;
    logic [7:0]  we_mask;
    logic [31:0] rdata;
    logic        err;
    lat = 0; we_mask = '0; rdata = '0; err = 1'b0;
    @(negedge clk);
    check({tag, "_ready"}, {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; req_we = ~we; req_addr = ~addr; req_wdata = ~wdata; req_funct3 = 3'b111;
    for (int k = 1; k <= 8; k++) begin
      if (k > 1) @(negedge clk);
      if (mem_we) we_mask[k] = 1'b1;
      if (rsp_valid) begin
        lat = k; rdata = rsp_rdata; err = rsp_err;
        break;
      end
    end
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_rdata"}, rdata, exp_rdata);
    check({tag, "_err"}, {31'b0, err}, {31'b0, exp_err});
    check({tag, "_we_mask"}, {24'b0, we_mask}, {24'b0, exp_we_mask});
    @(negedge clk);
    check({tag, "_pulse"}, {31'b0, rsp_valid}, 32'd0);
  endtask

  logic [8:0] rdy_v, vld_v;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    #12;
    check("rst_ready_o_state", {31'b0, rsp_valid}, 32'd0);
    check("rst_mem_we", {31'b0, mem_we}, 32'd0);
    check("rst_mem_a", mem_a, 32'h0);
    check("rst_mem_wd", mem_wd, 32'h0);
    check("rst_rdata", rsp_rdata, 32'h0);
    check("rst_err", {31'b0, rsp_err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", {31'b0, req_ready}, 32'd1);

    run("sw",  1'b1, 3'b010, 32'h10000, 32'hDEADBEEF, 32'h0,        1'b0, 2, 8'b0000_0010);
    run("lw",  1'b0, 3'b010, 32'h10000, 32'h0,        32'hDEADBEEF, 1'b0, 2, 8'b0);
    run("lbu", 1'b0, 3'b100, 32'h10003, 32'h0,        32'h000000DE, 1'b0, 2, 8'b0);
    run("lb",  1'b0, 3'b000, 32'h10000, 32'h0,        32'hFFFFFFEF, 1'b0, 2, 8'b0);
    run("lh",  1'b0, 3'b001, 32'h10000, 32'h0,        32'hFFFFBEEF, 1'b0, 2, 8'b0);
    run("lhu", 1'b0, 3'b101, 32'h10000, 32'h0,        32'h0000BEEF, 1'b0, 2, 8'b0);

    run("sw2", 1'b1, 3'b010, 32'h10004, 32'h11223344, 32'h0,        1'b0, 2, 8'b0000_0010);
    run("sb",  1'b1, 3'b000, 32'h10005, 32'hFFFFFFAA, 32'h0,        1'b0, 3, 8'b0000_0100);
    run("lw2", 1'b0, 3'b010, 32'h10004, 32'h0,        32'h1122AA44, 1'b0, 2, 8'b0);
    run("sh",  1'b1, 3'b001, 32'h10006, 32'hFFFF5566, 32'h0,        1'b0, 3, 8'b0000_0100);
    run("lw3", 1'b0, 3'b010, 32'h10004, 32'h0,        32'h5566AA44, 1'b0, 2, 8'b0);
    run("lh2", 1'b0, 3'b001, 32'h10006, 32'h0,        32'h00005566, 1'b0, 2, 8'b0);

    // Back-to-back loads with REQ_VALID held high.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10000;
    for (int i = 0; i < 9; i++) begin
      rdy_v[i] = req_ready;
      vld_v[i] = rsp_valid;
      @(negedge clk);
    end
    req_valid = 1'b0;
    check("b2b_ready", {23'b0, rdy_v}, {23'b0, 9'b001_001_001});
    check("b2b_valid", {23'b0, vld_v}, {23'b0, 9'b100_100_100});
    check("b2b_rdata", rsp_rdata, 32'hDEADBEEF);

    run("bad_f3",  1'b0, 3'b011, 32'h10000, 32'h0, 32'h0, 1'b1, 2, 8'b0);
    run("bad_sbu", 1'b1, 3'b100, 32'h10000, 32'h12345678, 32'h0, 1'b1, 2, 8'b0);
    run("lw_chk",  1'b0, 3'b010, 32'h10000, 32'h0, 32'hDEADBEEF, 1'b0, 2, 8'b0);
`ifdef MISALIGN_TRAP_EN
    run("lw_mis", 1'b0, 3'b010, 32'h10001, 32'h0, 32'h0, 1'b1, 2, 8'b0);
`else
    run("lw_mis", 1'b0, 3'b010, 32'h10001, 32'h0, 32'h44DEADBE, 1'b0, 2, 8'b0);
`endif

    // Reset in the middle of MERGE_WR abandons the pending write.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h10008; req_wdata = 32'h77;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("mrg_we_high", {31'b0, mem_we}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("mrg_rst_we", {31'b0, mem_we}, 32'd0);
    check("mrg_rst_a", mem_a, 32'h0);
    check("mrg_rst_valid", {31'b0, rsp_valid}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("mrg_rel_ready", {31'b0, req_ready}, 32'd1);
    check("mrg_rel_valid", {31'b0, rsp_valid}, 32'd0);
    run("lw_after_rst", 1'b0, 3'b010, 32'h10008, 32'h0, 32'h0, 1'b0, 2, 8'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
